// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the EX/MEM control bit layout and the default widths.
package pipe_pkg;

   localparam int unsigned B_DEF        = 32;
   localparam int unsigned CTRL_W_EXMEM = 6;

   localparam int unsigned CTRL_ZERO     = 0;
   localparam int unsigned CTRL_REGWRITE = 1;
   localparam int unsigned CTRL_MEMTOREG = 2;
   localparam int unsigned CTRL_BRANCH   = 3;
   localparam int unsigned CTRL_MEMREAD  = 4;
   localparam int unsigned CTRL_MEMWRITE = 5;

   // Where the main slot takes its next entry from.
   typedef enum logic {
      SrcIn,
      SrcSkid
   } main_src_e;

endpackage

// File: rtl/pipe_slot_reg.sv
// One held pipeline entry: valid bit plus data and control payload.
// clear beats load; payload registers change only on load.
module pipe_slot_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DW     = B_DEF,
   parameter int unsigned CTRL_W = CTRL_W_EXMEM
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DW-1:0]     d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DW-1:0]     data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_d, valid_q;
   logic [DW-1:0]     data_d, data_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = d_data;
         ctrl_d  = d_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_latch_skid.sv
// Pipeline-stage register with a two-entry skid buffer, flush and stall counter.
// in_ready comes purely from the skid slot's valid bit.
module pipe_latch_skid
   import pipe_pkg::*;
#(
   parameter int unsigned B      = B_DEF,
   parameter int unsigned N_DATA = 4,
   parameter int unsigned CTRL_W = CTRL_W_EXMEM,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_DATA*B-1:0]   in_data,
   input  logic [CTRL_W-1:0]     in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N_DATA*B-1:0]   out_data,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [1:0]            occupancy
);

   localparam int unsigned DW = N_DATA * B;
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic              main_valid, skid_valid;
   logic [DW-1:0]     main_data, skid_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

   logic              acc, pop;
   logic              main_load, main_clr, skid_load, skid_clr;
   main_src_e         main_src;
   logic [DW-1:0]     main_d_data;
   logic [CTRL_W-1:0] main_d_ctrl;

   logic [CNT_W-1:0]  cnt_d, cnt_q;

   assign in_ready = ~skid_valid;
   assign acc      = in_valid & in_ready;
   assign pop      = main_valid & out_ready;

   // Slot control; the main slot can never be empty while the skid slot is full.
   always_comb begin
      main_load = 1'b0;
      main_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      main_src  = SrcIn;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (!main_valid) begin
         main_load = acc;
      end else if (pop) begin
         if (skid_valid) begin
            main_load = 1'b1;
            main_src  = SrcSkid;
            skid_clr  = 1'b1;
         end else if (acc) begin
            main_load = 1'b1;
         end else begin
            main_clr = 1'b1;
         end
      end else begin
         skid_load = acc;
      end
   end

   assign main_d_data = (main_src == SrcSkid) ? skid_data : in_data;
   assign main_d_ctrl = (main_src == SrcSkid) ? skid_ctrl : in_ctrl;

   pipe_slot_reg #(
      .DW     (DW),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk    (clk),
      .reset  (reset),
      .load   (main_load),
      .clear  (main_clr),
      .d_data (main_d_data),
      .d_ctrl (main_d_ctrl),
      .valid  (main_valid),
      .data   (main_data),
      .ctrl   (main_ctrl)
   );

   pipe_slot_reg #(
      .DW     (DW),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clr),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .valid  (skid_valid),
      .data   (skid_data),
      .ctrl   (skid_ctrl)
   );

   // Stall counter survives flush; only reset clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (main_valid && !out_ready && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign stall_cnt = cnt_q;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
